// File: rtl/keysw_io_device.sv
// Memory-mapped KEY/SW input device: two-flop synchronizers, per-group debouncers, and
// data plus control/status registers with sticky Ready/Overrun and an interrupt enable.
module keysw_io_device #(
  parameter int unsigned     DBITS           = 32,
  parameter logic [DBITS-1:0] ADDRKDATA      = 32'hFFFFF080,
  parameter logic [DBITS-1:0] ADDRKCTRL      = 32'hFFFFF084,
  parameter logic [DBITS-1:0] ADDRSDATA      = 32'hFFFFF090,
  parameter logic [DBITS-1:0] ADDRSCTRL      = 32'hFFFFF094,
  parameter int unsigned     DEBOUNCE_CYCLES = 500000,
  parameter int unsigned     CNTBITS         = 20
) (
  input  logic             _clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr_i,
  input  logic [DBITS-1:0] wrdata_i,
  input  logic             wren_i,
  input  logic             rden_i,
  output logic [DBITS-1:0] rddata_o,
  output logic             sel_o,
  output logic             intr_o
);

  localparam logic [CNTBITS-1:0] CntLast = CNTBITS'(DEBOUNCE_CYCLES - 1);

  logic [3:0]         r_key_s1, r_key_s2, r_key_cand, r_key_stable;
  logic [9:0]         r_sw_s1, r_sw_s2, r_sw_cand, r_sw_stable;
  logic [CNTBITS-1:0] r_key_cnt, r_sw_cnt;
  logic               r_krdy, r_kovr, r_kie, r_srdy, r_sovr, r_sie;
  logic               w_key_commit, w_sw_commit;
  logic               w_kdata_hit, w_kctrl_hit, w_sdata_hit, w_sctrl_hit;
  logic               w_krd, w_kwr, w_srd, w_swr;
  logic [DBITS-1:0]   w_rddata;
  logic               w_unused;

  always_ff @(posedge _clk or posedge reset) begin
    if (reset) begin
      r_key_s1 <= 4'hF;
      r_key_s2 <= 4'hF;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_key_s1 <= KEY;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
    end
  end

  assign w_key_commit = (r_key_s2 != r_key_stable) && (r_key_s2 == r_key_cand) &&
                        (r_key_cnt == CntLast);
  assign w_sw_commit  = (r_sw_s2 != r_sw_stable) && (r_sw_s2 == r_sw_cand) &&
                        (r_sw_cnt == CntLast);

  always_ff @(posedge _clk or posedge reset) begin
    if (reset) begin
      r_key_cand   <= 4'hF;
      r_key_stable <= 4'hF;
      r_key_cnt    <= '0;
    end else if (r_key_s2 == r_key_stable) begin
      r_key_cand <= r_key_s2;
      r_key_cnt  <= '0;
    end else if (r_key_s2 != r_key_cand) begin
      r_key_cand <= r_key_s2;
      r_key_cnt  <= '0;
    end else if (r_key_cnt == CntLast) begin
      r_key_stable <= r_key_cand;
      r_key_cnt    <= '0;
    end else begin
      r_key_cnt <= r_key_cnt + CNTBITS'(1);
    end
  end

  always_ff @(posedge _clk or posedge reset) begin
    if (reset) begin
      r_sw_cand   <= '0;
      r_sw_stable <= '0;
      r_sw_cnt    <= '0;
    end else if (r_sw_s2 == r_sw_stable) begin
      r_sw_cand <= r_sw_s2;
      r_sw_cnt  <= '0;
    end else if (r_sw_s2 != r_sw_cand) begin
      r_sw_cand <= r_sw_s2;
      r_sw_cnt  <= '0;
    end else if (r_sw_cnt == CntLast) begin
      r_sw_stable <= r_sw_cand;
      r_sw_cnt    <= '0;
    end else begin
      r_sw_cnt <= r_sw_cnt + CNTBITS'(1);
    end
  end

  assign w_kdata_hit = (addr_i == ADDRKDATA);
  assign w_kctrl_hit = (addr_i == ADDRKCTRL);
  assign w_sdata_hit = (addr_i == ADDRSDATA);
  assign w_sctrl_hit = (addr_i == ADDRSCTRL);
  assign w_krd = rden_i && w_kdata_hit;
  assign w_srd = rden_i && w_sdata_hit;
  assign w_kwr = wren_i && w_kctrl_hit;
  assign w_swr = wren_i && w_sctrl_hit;

  // Commit beats a same-cycle data read or Overrun-clearing write.
  always_ff @(posedge _clk or posedge reset) begin
    if (reset) begin
      r_krdy <= 1'b0;
      r_kovr <= 1'b0;
      r_kie  <= 1'b0;
      r_srdy <= 1'b0;
      r_sovr <= 1'b0;
      r_sie  <= 1'b0;
    end else begin
      if (w_key_commit)     r_krdy <= 1'b1;
      else if (w_krd)       r_krdy <= 1'b0;
      if (w_key_commit && r_krdy && !w_krd) r_kovr <= 1'b1;
      else if (w_kwr && !wrdata_i[2])       r_kovr <= 1'b0;
      if (w_kwr)            r_kie <= wrdata_i[8];

      if (w_sw_commit)      r_srdy <= 1'b1;
      else if (w_srd)       r_srdy <= 1'b0;
      if (w_sw_commit && r_srdy && !w_srd) r_sovr <= 1'b1;
      else if (w_swr && !wrdata_i[2])      r_sovr <= 1'b0;
      if (w_swr)            r_sie <= wrdata_i[8];
    end
  end

  always_comb begin
    w_rddata = '0;
    if (w_kdata_hit) begin
      w_rddata[3:0] = ~r_key_stable;
    end else if (w_kctrl_hit) begin
      w_rddata[0] = r_krdy;
      w_rddata[2] = r_kovr;
      w_rddata[8] = r_kie;
    end else if (w_sdata_hit) begin
      w_rddata[9:0] = r_sw_stable;
    end else if (w_sctrl_hit) begin
      w_rddata[0] = r_srdy;
      w_rddata[2] = r_sovr;
      w_rddata[8] = r_sie;
    end
  end

  assign rddata_o = w_rddata;
  assign sel_o    = w_kdata_hit | w_kctrl_hit | w_sdata_hit | w_sctrl_hit;
  assign intr_o   = (r_krdy & r_kie) | (r_srdy & r_sie);

  assign w_unused = ^{wrdata_i[DBITS-1:9], wrdata_i[7:3], wrdata_i[1:0]};

endmodule

// File: tb/tb_keysw_io_device.sv
// Scoreboard bench for keysw_io_device with a short debounce window (4 cycles).
module tb_keysw_io_device;

  localparam logic [31:0] AKD = 32'hFFFFF080;
  localparam logic [31:0] AKC = 32'hFFFFF084;
  localparam logic [31:0] ASD = 32'hFFFFF090;
  localparam logic [31:0] ASC = 32'hFFFFF094;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [3:0]  key    = 4'hF;
  logic [9:0]  sw     = 10'h000;
  logic [31:0] addr   = '0;
  logic [31:0] wrdata = '0;
  logic        wren   = 1'b0;
  logic        rden   = 1'b0;
  logic [31:0] rddata;
  logic        sel;
  logic        intr;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #10 clk = ~clk;

  keysw_io_device #(
    .DEBOUNCE_CYCLES(4),
    .CNTBITS        (3)
  ) u_dut (
    ._clk    (clk),
    .reset   (reset),
    .KEY     (key),
    .SW      (sw),
    .addr_i  (addr),
    .wrdata_i(wrdata),
    .wren_i  (wren),
    .rden_i  (rden),
    .rddata_o(rddata),
    .sel_o   (sel),
    .intr_o  (intr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Combinational read with no strobe.
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] e);
    addr = a;
    rden = 1'b0;
    wren = 1'b0;
    exp_q.push_back(e);
    #1;
    check(tag, rddata, exp_q.pop_front());
  endtask

  // Strobed read; the strobe cycle ends at the next edge.
  task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    addr = a;
    rden = 1'b1;
    exp_q.push_back(e);
    #1;
    check(tag, rddata, exp_q.pop_front());
    @(posedge clk);
    #1;
    rden = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    wrdata = d;
    wren   = 1'b1;
    step(1);
    wren   = 1'b0;
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    peek("rst_kd", AKD, 32'h0);
    peek("rst_kc", AKC, 32'h0);
    peek("rst_sd", ASD, 32'h0);
    peek("rst_sc", ASC, 32'h0);
    check("rst_intr", {31'b0, intr}, 32'h0);

    // Key press: commit 7 edges after the raw change.
    key = 4'hE;
    step(6);
    peek("kp_early", AKD, 32'h0);
    step(1);
    peek("kp_kd", AKD, 32'h1);
    peek("kp_kc", AKC, 32'h1);
    bus_rd("kp_rd", AKD, 32'h1);
    peek("kp_kc_clr", AKC, 32'h0);
    peek("kp_kd_hold", AKD, 32'h1);

    key = 4'hF;
    step(7);
    peek("kr_kd", AKD, 32'h0);
    peek("kr_kc", AKC, 32'h1);
    bus_rd("kr_rd", AKD, 32'h0);
    peek("kr_kc_clr", AKC, 32'h0);
    bus_wr(AKC, 32'h100);
    peek("kie_set", AKC, 32'h100);

    // Asynchronous reset mid-cycle while a KEY change is pending.
    key = 4'h0;
    step(3);
    #3;
    reset = 1'b1;
    #1;
    peek("arst_kd", AKD, 32'h0);
    peek("arst_kc", AKC, 32'h0);
    peek("arst_sd", ASD, 32'h0);
    peek("arst_sc", ASC, 32'h0);
    check("arst_intr", {31'b0, intr}, 32'h0);
    key = 4'hF;
    step(1);
    #3;
    reset = 1'b0;
    step(3);
    peek("post_kd", AKD, 32'h0);
    peek("post_kc", AKC, 32'h0);

    // Bounce: toggles never last long enough to commit.
    for (int i = 0; i < 5; i++) begin
      sw = 10'h001;
      step(2);
      sw = 10'h000;
      step(2);
    end
    peek("bn_none", ASC, 32'h0);
    sw = 10'h001;
    step(6);
    peek("bn_early", ASD, 32'h0);
    step(1);
    peek("bn_sd", ASD, 32'h1);
    peek("bn_sc", ASC, 32'h1);

    // Second commit without a read sets Overrun.
    sw = 10'h003;
    step(7);
    peek("ov_sd", ASD, 32'h3);
    peek("ov_sc", ASC, 32'h5);
    bus_wr(ASC, 32'h0);
    peek("ov_clr", ASC, 32'h1);
    bus_wr(ASC, 32'h4);
    peek("ov_w1", ASC, 32'h1);
    bus_wr(ASD, 32'h3FF);
    peek("sd_ro", ASD, 32'h3);

    // Commit coincides with a strobed SDATA read.
    sw = 10'h007;
    step(6);
    bus_rd("col_rd", ASD, 32'h3);
    peek("col_sd", ASD, 32'h7);
    peek("col_sc", ASC, 32'h1);
    peek("unmapped", 32'hFFFFF088, 32'h0);
    check("unmapped_sel", {31'b0, sel}, 32'h0);
    peek("mapped", AKD, 32'h0);
    check("mapped_sel", {31'b0, sel}, 32'h1);

    // Interrupt from KEY with IE set.
    bus_wr(AKC, 32'h100);
    key = 4'h7;
    step(6);
    check("irq_early", {31'b0, intr}, 32'h0);
    step(1);
    check("irq_rise", {31'b0, intr}, 32'h1);
    peek("irq_kd", AKD, 32'h8);
    step(2);
    check("irq_hold", {31'b0, intr}, 32'h1);
    bus_rd("irq_rd", AKD, 32'h8);
    check("irq_fall", {31'b0, intr}, 32'h0);

    // Commit with IE cleared never interrupts.
    bus_wr(AKC, 32'h0);
    key = 4'hF;
    step(7);
    check("noie_intr", {31'b0, intr}, 32'h0);
    peek("noie_kc", AKC, 32'h1);
    peek("noie_kd", AKD, 32'h0);
    bus_wr(ASC, 32'h100);
    check("sie_intr", {31'b0, intr}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
